tdm_mux_scanner: RTL

Parametrised, registered N-channel multiplexer, the sequential successor to the team's 3-input mux cell. It selects one WIDTH-bit channel out of CHANNELS, either from an external select (static mode) or from an internal round-robin scan counter (scan mode). The output is registered and carries valid, index and wrap flags. It feeds the datapath labs as a time-division channel sampler.

---
 rtl/tdm_mux_scanner.sv | 110 +++++++++++
 1 files changed

// File: rtl/tdm_mux_scanner.sv
// Registered N-channel mux with static select and round-robin scan modes.
// Optional MUX_INV_EN adds a per-channel output inversion mask.
module tdm_mux_scanner #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [WIDTH*CHANNELS-1:0] data,
`ifdef MUX_INV_EN
  input  logic [CHANNELS-1:0]       inv_mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          ch_idx,
  output logic                      wrap,
  output logic                      err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] cnt_nxt;
  logic             mode_q;

  logic             entry;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] pick_idx;
  logic             in_range;
  logic [WIDTH-1:0] picked;

  logic [WIDTH-1:0] y_nxt;
  logic             valid_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  // A rising mode edge restarts the scan at channel 0.
  always_comb begin
    entry    = mode & ~mode_q;
    scan_idx = entry ? '0 : cnt;
    pick_idx = mode ? scan_idx : sel;
    in_range = mode | (sel <= LAST);
  end

  always_comb begin
    picked = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick_idx == SEL_W'(k)) begin
        picked = data[k*WIDTH +: WIDTH];
`ifdef MUX_INV_EN
        if (inv_mask[k]) picked = ~data[k*WIDTH +: WIDTH];
`endif
      end
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    y_nxt     = y;
    idx_nxt   = ch_idx;
    err_nxt   = err;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    if (en) begin
      idx_nxt = pick_idx;
      if (!in_range) begin
        y_nxt   = '0;
        err_nxt = 1'b1;
      end else begin
        y_nxt     = picked;
        err_nxt   = 1'b0;
        valid_nxt = 1'b1;
      end
      if (mode) begin
        if (scan_idx == LAST) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = scan_idx + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      mode_q  <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      ch_idx  <= '0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      mode_q  <= mode;
      y       <= y_nxt;
      y_valid <= valid_nxt;
      ch_idx  <= idx_nxt;
      wrap    <= wrap_nxt;
      err     <= err_nxt;
    end
  end

endmodule
